cba_cfg_driver: RTL

Upstream driver of the core-column CBA configuration chain; feeds the first core's RowIn/DataIn/PhiAzIn/SelC2fIn/SelC4fIn/FastEnIn/WriteSyncTimeIn.
- Accepts pixel-configuration write requests from the global configuration/command block over a valid/ready handshake.
- Sequences each request onto the row/data bus with setup, write and hold phases.
- Generates the synchronous-FE auto-zero pulse (PhiAz), periodic or on request.
- Applies global FE settings glitch-free, only at quiet points.

---
 rtl/cba_pkg.sv | 35 +++
 rtl/cba_az_timer.sv | 58 +++++
 rtl/cba_cfg_driver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cba_pkg.sv
// Shared types and constants for the CBA configuration-chain driver.
package cba_pkg;

    // Driver sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_AZ    = 3'd4
    } cba_state_e;

    // Default bus widths of the core-column configuration chain.
    localparam int CBA_ROW_BITS        = 8;
    localparam int CBA_DATA_BITS       = 16;
    localparam int CBA_SG_LATENCY_BITS = 9;

    // Default write-sequence phase lengths and auto-zero counter width.
    localparam int DEF_SETUP_CYC   = 2;
    localparam int DEF_WRITE_CYC   = 2;
    localparam int DEF_HOLD_CYC    = 1;
    localparam int DEF_AZ_CNT_BITS = 16;

    // Phase counter width; must hold every phase length and an 8-bit AZ width.
    localparam int PHASE_BITS = 8;

    // "No row selected" code on the default-width row bus.
    localparam logic [CBA_ROW_BITS-1:0] ROW_IDLE = '1;

    // An auto-zero width of zero still yields a one-cycle pulse.
    function automatic logic [7:0] az_width_eff(input logic [7:0] width);
        return (width == 8'd0) ? 8'd1 : width;
    endfunction

endpackage

// File: rtl/cba_az_timer.sv
// Auto-zero scheduler: free-running period counter plus a sticky pending flag
// that merges periodic expiries and one-shot requests until acknowledged.
module cba_az_timer #(
    parameter int AZ_CNT_BITS = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_az_en,
    input  logic [AZ_CNT_BITS-1:0] i_az_period,
    input  logic                   i_az_req,
    input  logic                   i_az_ack,
    output logic                   o_az_pending
);

    logic [AZ_CNT_BITS-1:0] r_cnt;
    logic                   r_run;
    logic                   r_pending;
    logic                   w_enabled;
    logic                   w_expire;

    // A zero period disables periodic pulses even with the enable set.
    assign w_enabled = i_az_en && (i_az_period != '0);
    assign w_expire  = w_enabled && r_run && (r_cnt == '0);

    // Down-counter: loads period-1 on start, reloads on every expiry,
    // cleared whenever periodic auto-zero is disabled.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values and simulation matches the synthesized flops.
        if (i_reset) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (!w_enabled) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (!r_run || (r_cnt == '0)) begin
            r_cnt <= i_az_period - 1'b1;
            r_run <= 1'b1;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Pending flag: set by expiry or request (setting wins), cleared by the
    // acknowledge issued when the driver enters its AZ state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending <= 1'b0;
        end else if (w_expire || i_az_req) begin
            r_pending <= 1'b1;
        end else if (i_az_ack) begin
            r_pending <= 1'b0;
        end
    end

    assign o_az_pending = r_pending;

endmodule

// File: rtl/cba_cfg_driver.sv
// Upstream driver of the core-column CBA configuration chain: sequences pixel
// writes onto the row/data bus, issues auto-zero pulses and applies global FE
// settings only while the chain is quiet.
module cba_cfg_driver
    import cba_pkg::*;
#(
    parameter int ROW_BITS    = CBA_ROW_BITS,
    parameter int DATA_BITS   = CBA_DATA_BITS,
    parameter int LAT_BITS    = CBA_SG_LATENCY_BITS,
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int WRITE_CYC   = DEF_WRITE_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int AZ_CNT_BITS = DEF_AZ_CNT_BITS
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic [ROW_BITS-1:0]    i_wr_row,
    input  logic [DATA_BITS-1:0]   i_wr_data,
    input  logic                   i_az_en,
    input  logic [AZ_CNT_BITS-1:0] i_az_period,
    input  logic [7:0]             i_az_width,
    input  logic                   i_az_req,
    input  logic                   i_cfg_sel_c2f,
    input  logic                   i_cfg_sel_c4f,
    input  logic                   i_cfg_fast_en,
    input  logic [LAT_BITS-1:0]    i_cfg_sync_time,
    output logic [ROW_BITS-1:0]    o_row_out,
    output logic [DATA_BITS-1:0]   o_data_out,
    output logic                   o_wr_en,
    output logic                   o_phi_az_out,
    output logic                   o_sel_c2f_out,
    output logic                   o_sel_c4f_out,
    output logic                   o_fast_en_out,
    output logic [LAT_BITS-1:0]    o_write_sync_time_out,
    output logic                   o_busy
);

    localparam logic [ROW_BITS-1:0]   ROW_NONE   = '1;
    localparam logic [PHASE_BITS-1:0] SETUP_LAST = PHASE_BITS'(SETUP_CYC - 1);
    localparam logic [PHASE_BITS-1:0] WRITE_LAST = PHASE_BITS'(WRITE_CYC - 1);
    localparam logic [PHASE_BITS-1:0] HOLD_LAST  = PHASE_BITS'(HOLD_CYC - 1);

    cba_state_e            r_state;
    cba_state_e            w_state_nxt;
    logic [PHASE_BITS-1:0] r_phase;
    logic [PHASE_BITS-1:0] w_phase_nxt;
    logic [7:0]            r_az_last;
    logic                  r_ready_en;
    logic                  w_az_pending;
    logic                  w_az_ack;
    logic                  w_accept;
    logic                  w_quiet;

    logic [ROW_BITS-1:0]   r_row;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_wr_en;
    logic                  r_phi_az;
    logic                  r_busy;
    logic                  r_sel_c2f;
    logic                  r_sel_c4f;
    logic                  r_fast_en;
    logic [LAT_BITS-1:0]   r_sync_time;

    cba_az_timer #(
        .AZ_CNT_BITS (AZ_CNT_BITS)
    ) u_az_timer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_az_en      (i_az_en),
        .i_az_period  (i_az_period),
        .i_az_req     (i_az_req),
        .i_az_ack     (w_az_ack),
        .o_az_pending (w_az_pending)
    );

    // r_ready_en holds ready low through reset and releases it one edge later.
    assign o_wr_ready = r_ready_en && (r_state == ST_IDLE) && !w_az_pending;

    // Next-state decode; pending auto-zero takes priority over a write request.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_accept    = 1'b0;
        w_az_ack    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_az_pending) begin
                    w_state_nxt = ST_AZ;
                    w_phase_nxt = '0;
                    w_az_ack    = 1'b1;
                end else if (i_wr_valid && o_wr_ready) begin
                    w_state_nxt = ST_SETUP;
                    w_phase_nxt = '0;
                    w_accept    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (r_phase == SETUP_LAST) begin
                    w_state_nxt = ST_WRITE;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            ST_WRITE: begin
                if (r_phase == WRITE_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_phase == HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            ST_AZ: begin
                if (r_phase == r_az_last) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    // Settings may only move when the FSM stays idle across the edge.
    assign w_quiet = (r_state == ST_IDLE) && (w_state_nxt == ST_IDLE);

    // State register and registered chain outputs derived from the next state,
    // so strobes line up exactly with the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_az_last  <= '0;
            r_ready_en <= 1'b0;
            r_row      <= ROW_NONE;
            r_data     <= '0;
            r_wr_en    <= 1'b0;
            r_phi_az   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_ready_en <= 1'b1;
            r_wr_en    <= (w_state_nxt == ST_WRITE);
            r_phi_az   <= (w_state_nxt == ST_AZ);
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (w_az_ack) begin
                r_az_last <= az_width_eff(i_az_width) - 8'd1;
            end
            if (w_accept) begin
                r_row  <= i_wr_row;
                r_data <= i_wr_data;
            end else if ((r_state == ST_HOLD) && (w_state_nxt == ST_IDLE)) begin
                r_row  <= ROW_NONE;
            end
        end
    end

    // Global FE shadow registers, refreshed only at quiet points.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sel_c2f   <= 1'b0;
            r_sel_c4f   <= 1'b0;
            r_fast_en   <= 1'b0;
            r_sync_time <= '0;
        end else if (w_quiet) begin
            r_sel_c2f   <= i_cfg_sel_c2f;
            r_sel_c4f   <= i_cfg_sel_c4f;
            r_fast_en   <= i_cfg_fast_en;
            r_sync_time <= i_cfg_sync_time;
        end
    end

    assign o_row_out             = r_row;
    assign o_data_out            = r_data;
    assign o_wr_en               = r_wr_en;
    assign o_phi_az_out          = r_phi_az;
    assign o_busy                = r_busy;
    assign o_sel_c2f_out         = r_sel_c2f;
    assign o_sel_c4f_out         = r_sel_c4f;
    assign o_fast_en_out         = r_fast_en;
    assign o_write_sync_time_out = r_sync_time;

endmodule
